// File: rtl/rx_hop_sync_ctrl_if.sv
// Sample input and AXI-Stream output bundle of the receive hop tracker.
// The master modport is the tracker's view. The slave modport is the view of the radio front end and the downstream consumer.
interface rx_hop_sync_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NHOP_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   irx;
  logic [DATA_WIDTH-1:0]   qrx;
  logic                    in_tvalid;
  logic [2*DATA_WIDTH-1:0] out_tdata;
  logic                    out_tvalid;
  logic                    out_tready;
  logic                    out_tlast;
  logic [NHOP_WIDTH-1:0]   out_tuser;

  modport master (
    input  irx, qrx, in_tvalid, out_tready,
    output out_tdata, out_tvalid, out_tlast, out_tuser
  );

  modport slave (
    output irx, qrx, in_tvalid, out_tready,
    input  out_tdata, out_tvalid, out_tlast, out_tuser
  );
endinterface

// File: rtl/rx_hop_sync_ctrl.sv
// Receive hop tracker: validates the tag sync pulse length, frames the following hop of IQ samples and steps the hop index and NCO increment.
// Define RX_HOP_SYNC_STATS_EN to add the sync_len statistics output.
module rx_hop_sync_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int PHASE_WIDTH   = 24,
  parameter int NHOP_WIDTH    = 8,
  parameter int NSYMB_WIDTH   = 16,
  parameter int NUM_HOPS      = 64,
  parameter int NSYMB_PER_HOP = 8,
  parameter int NSIG          = 16384,
  parameter int SYNC_TOL      = 64,
  parameter logic [PHASE_WIDTH-1:0] START_PH_INC = -24'd4194304,
  parameter logic [PHASE_WIDTH-1:0] HOP_DPH_INC  = 24'd131072
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync_in,
  rx_hop_sync_ctrl_if.master     bus,
  output logic [PHASE_WIDTH-1:0] hop_ph_inc,
  output logic [NHOP_WIDTH-1:0]  nhop,
  output logic [NSYMB_WIDTH-1:0] symbN,
  output logic [1:0]             rx_state,
  output logic                   sync_err,
  output logic                   overflow
`ifdef RX_HOP_SYNC_STATS_EN
  ,
  output logic [PHASE_WIDTH-1:0] sync_len
`endif
);

  localparam int SCNT_W = $clog2(NSIG + 1);
  localparam int SYNC_W = $clog2(NSIG + SYNC_TOL + 2);

  localparam logic [SCNT_W-1:0]      SCNT_LAST = SCNT_W'(NSIG - 1);
  localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST = NSYMB_WIDTH'(NSYMB_PER_HOP - 1);
  localparam logic [NHOP_WIDTH-1:0]  HOP_LAST  = NHOP_WIDTH'(NUM_HOPS - 1);
  localparam logic [SYNC_W-1:0]      SYNC_MAX  = SYNC_W'(NSIG + SYNC_TOL);
  localparam logic [SYNC_W-1:0]      SYNC_MIN  = SYNC_W'(NSIG - SYNC_TOL);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEAS     = 2'b01,
    RX       = 2'b11,
    WAIT_LOW = 2'b10
  } rxState_e;

  rxState_e                state_q, state_d;
  logic [SYNC_W-1:0]       syncCnt_q, syncCnt_d;
  logic [SCNT_W-1:0]       sampleCnt_q, sampleCnt_d;
  logic [NSYMB_WIDTH-1:0]  symb_q, symb_d;
  logic [NHOP_WIDTH-1:0]   nhop_q, nhop_d;
  logic [PHASE_WIDTH-1:0]  phInc_q, phInc_d;
  logic [2*DATA_WIDTH-1:0] outData_q, outData_d;
  logic                    outValid_q, outValid_d;
  logic                    outLast_q, outLast_d;
  logic [NHOP_WIDTH-1:0]   outUser_q, outUser_d;
  logic                    syncErr_q, syncErr_d;
  logic                    overflow_q, overflow_d;

  logic [SYNC_W-1:0]       syncCntInc;
  logic                    fwd;
  logic                    fwdLast;
  logic                    hopAdv;
  logic [SCNT_W-1:0]       posScnt;
  logic [NSYMB_WIDTH-1:0]  posSymb;

  assign syncCntInc = syncCnt_q + SYNC_W'(1);

  always_comb begin
    state_d     = state_q;
    syncCnt_d   = syncCnt_q;
    sampleCnt_d = sampleCnt_q;
    symb_d      = symb_q;
    nhop_d      = nhop_q;
    phInc_d     = phInc_q;
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;
    outUser_d   = outUser_q;
    syncErr_d   = 1'b0;
    overflow_d  = overflow_q;
    fwd         = 1'b0;
    fwdLast     = 1'b0;
    hopAdv      = 1'b0;
    posScnt     = sampleCnt_q;
    posSymb     = symb_q;

    if (bus.in_tvalid) begin
      case (state_q)
        IDLE: begin
          if (sync_in) begin
            state_d   = MEAS;
            syncCnt_d = SYNC_W'(1);
          end
        end
        MEAS: begin
          if (sync_in) begin
            if (syncCntInc > SYNC_MAX) begin
              syncErr_d = 1'b1;
              state_d   = WAIT_LOW;
            end else begin
              syncCnt_d = syncCntInc;
            end
          end else if (syncCnt_q >= SYNC_MIN) begin
            // The first low sample after an accepted sync is already sample 0 of the hop
            state_d = RX;
            fwd     = 1'b1;
            posScnt = '0;
            posSymb = '0;
          end else begin
            syncErr_d = 1'b1;
            state_d   = IDLE;
          end
        end
        RX: begin
          if (sync_in) begin
            syncErr_d = 1'b1;
            hopAdv    = 1'b1;
            state_d   = MEAS;
            syncCnt_d = SYNC_W'(1);
          end else begin
            fwd = 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!sync_in) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (fwd) begin
      fwdLast = (posSymb == SYMB_LAST) && (posScnt == SCNT_LAST);
      if (fwdLast) begin
        hopAdv  = 1'b1;
        state_d = IDLE;
      end else if (posScnt == SCNT_LAST) begin
        sampleCnt_d = '0;
        symb_d      = posSymb + NSYMB_WIDTH'(1);
      end else begin
        sampleCnt_d = posScnt + SCNT_W'(1);
        symb_d      = posSymb;
      end
    end

    if (hopAdv) begin
      sampleCnt_d = '0;
      symb_d      = '0;
      if (nhop_q == HOP_LAST) begin
        nhop_d  = '0;
        phInc_d = START_PH_INC;
      end else begin
        nhop_d  = nhop_q + NHOP_WIDTH'(1);
        phInc_d = phInc_q + HOP_DPH_INC;
      end
    end

    // Single output stage: a stalled sample drops the new one, counters above keep running
    if (fwd) begin
      if (outValid_q && !bus.out_tready) begin
        overflow_d = 1'b1;
      end else begin
        outData_d  = {bus.irx, bus.qrx};
        outValid_d = 1'b1;
        outLast_d  = fwdLast;
        outUser_d  = nhop_q;
      end
    end else if (bus.out_tready) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      syncCnt_q   <= '0;
      sampleCnt_q <= '0;
      symb_q      <= '0;
      nhop_q      <= '0;
      phInc_q     <= START_PH_INC;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      outUser_q   <= '0;
      syncErr_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      syncCnt_q   <= syncCnt_d;
      sampleCnt_q <= sampleCnt_d;
      symb_q      <= symb_d;
      nhop_q      <= nhop_d;
      phInc_q     <= phInc_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
      outUser_q   <= outUser_d;
      syncErr_q   <= syncErr_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef RX_HOP_SYNC_STATS_EN
  logic [PHASE_WIDTH-1:0] syncLen_q, syncLen_d;
  logic                   measExit;
  logic [SYNC_W-1:0]      lenSrc;

  // A rejected over-long sync reports the count that tripped the limit
  always_comb begin
    measExit  = (state_q == MEAS) && bus.in_tvalid && (!sync_in || (syncCntInc > SYNC_MAX));
    lenSrc    = sync_in ? syncCntInc : syncCnt_q;
    syncLen_d = syncLen_q;
    if (measExit) begin
      if ((SYNC_W > PHASE_WIDTH) && ((lenSrc >> PHASE_WIDTH) != '0)) begin
        syncLen_d = '1;
      end else begin
        syncLen_d = PHASE_WIDTH'(lenSrc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      syncLen_q <= '0;
    end else begin
      syncLen_q <= syncLen_d;
    end
  end

  assign sync_len = syncLen_q;
`endif

  assign bus.out_tdata  = outData_q;
  assign bus.out_tvalid = outValid_q;
  assign bus.out_tlast  = outLast_q;
  assign bus.out_tuser  = outUser_q;
  assign hop_ph_inc     = phInc_q;
  assign nhop           = nhop_q;
  assign symbN          = symb_q;
  assign rx_state       = state_q;
  assign sync_err       = syncErr_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_rx_hop_sync_ctrl.sv
// Directed testbench for rx_hop_sync_ctrl with NSIG=16, SYNC_TOL=2, NSYMB_PER_HOP=2 and NUM_HOPS=4.
// It checks sync_len as well when RX_HOP_SYNC_STATS_EN is defined.
module tb_rx_hop_sync_ctrl;
  localparam int DW = 16;
  localparam int PW = 24;
  localparam int HW = 8;
  localparam int SW = 16;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MEAS = 2'b01;
  localparam logic [1:0] ST_RX   = 2'b11;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [PW-1:0] START = 24'hC00000;
  localparam logic [PW-1:0] DPH   = 24'h020000;

  logic clk = 1'b0;
  logic reset;
  logic sync_in;
  logic [PW-1:0] hop_ph_inc;
  logic [HW-1:0] nhop;
  logic [SW-1:0] symbN;
  logic [1:0]    rx_state;
  logic          sync_err;
  logic          overflow;
`ifdef RX_HOP_SYNC_STATS_EN
  logic [PW-1:0] sync_len;
`endif

  int checks = 0;
  int failures = 0;
  int errCount = 0;
  logic [DW-1:0] dataCnt = '0;
  logic [2*DW-1:0] txData[$];
  logic            txLast[$];
  logic [HW-1:0]   txUser[$];

  rx_hop_sync_ctrl_if #(.DATA_WIDTH(DW), .NHOP_WIDTH(HW)) bus ();

  rx_hop_sync_ctrl #(
    .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .NHOP_WIDTH(HW), .NSYMB_WIDTH(SW),
    .NUM_HOPS(4), .NSYMB_PER_HOP(2), .NSIG(16), .SYNC_TOL(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sync_in(sync_in),
    .bus(bus),
    .hop_ph_inc(hop_ph_inc),
    .nhop(nhop),
    .symbN(symbN),
    .rx_state(rx_state),
    .sync_err(sync_err),
    .overflow(overflow)
`ifdef RX_HOP_SYNC_STATS_EN
    ,
    .sync_len(sync_len)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_tvalid && bus.out_tready) begin
        txData.push_back(bus.out_tdata);
        txLast.push_back(bus.out_tlast);
        txUser.push_back(bus.out_tuser);
      end
      if (sync_err) errCount++;
    end
  end

  function automatic logic [2*DW-1:0] expData(input logic [DW-1:0] v);
    return {v, ~v};
  endfunction

  task automatic drive(input logic s, input logic v);
    sync_in = s;
    bus.in_tvalid = v;
    bus.irx = dataCnt;
    bus.qrx = ~dataCnt;
    @(posedge clk);
    #1;
    if (v) dataCnt++;
  endtask

  task automatic sendSync(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1);
  endtask

  task automatic sendData(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    sync_in = 1'b0;
    bus.in_tvalid = 1'b0;
    bus.out_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (rx_state !== ST_IDLE) begin failures++; $display("[TB] FAIL reset_state: got %b expected %b", rx_state, ST_IDLE); end
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid: got %b expected 0", bus.out_tvalid); end
    checks++; if (bus.out_tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast: got %b expected 0", bus.out_tlast); end
    checks++; if (bus.out_tdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_tdata: got %h expected 0", bus.out_tdata); end
    checks++; if (bus.out_tuser !== 8'h0) begin failures++; $display("[TB] FAIL reset_tuser: got %h expected 0", bus.out_tuser); end
    checks++; if (nhop !== 8'h0) begin failures++; $display("[TB] FAIL reset_nhop: got %h expected 0", nhop); end
    checks++; if (symbN !== 16'h0) begin failures++; $display("[TB] FAIL reset_symbN: got %h expected 0", symbN); end
    checks++; if (hop_ph_inc !== START) begin failures++; $display("[TB] FAIL reset_ph_inc: got %h expected %h", hop_ph_inc, START); end
    checks++; if (sync_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_sync_err: got %b expected 0", sync_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
`ifdef RX_HOP_SYNC_STATS_EN
    checks++; if (sync_len !== 24'h0) begin failures++; $display("[TB] FAIL reset_sync_len: got %h expected 0", sync_len); end
`endif
  endtask

  task automatic test_single_hop();
    int txBase;
    int errBase;
    logic [DW-1:0] base;
    doReset();
    txBase = txData.size();
    errBase = errCount;
    sendSync(16);
    base = dataCnt;
    sendData(1);
    checks++; if (bus.out_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL hop_latency_tvalid: got %b expected 1", bus.out_tvalid); end
    checks++; if (bus.out_tdata !== expData(base)) begin failures++; $display("[TB] FAIL hop_first_data: got %h expected %h", bus.out_tdata, expData(base)); end
    checks++; if (rx_state !== ST_RX) begin failures++; $display("[TB] FAIL hop_state_rx: got %b expected %b", rx_state, ST_RX); end
`ifdef RX_HOP_SYNC_STATS_EN
    checks++; if (sync_len !== 24'd16) begin failures++; $display("[TB] FAIL hop_sync_len: got %0d expected 16", sync_len); end
`endif
    sendData(16);
    checks++; if (symbN !== 16'd1) begin failures++; $display("[TB] FAIL hop_symbN: got %0d expected 1", symbN); end
    sendData(15);
    checks++; if (rx_state !== ST_IDLE) begin failures++; $display("[TB] FAIL hop_end_state: got %b expected %b", rx_state, ST_IDLE); end
    checks++; if (nhop !== 8'd1) begin failures++; $display("[TB] FAIL hop_end_nhop: got %0d expected 1", nhop); end
    checks++; if (hop_ph_inc !== START + DPH) begin failures++; $display("[TB] FAIL hop_end_ph_inc: got %h expected %h", hop_ph_inc, START + DPH); end
    idle(2);
    checks++; if (txData.size() - txBase !== 32) begin failures++; $display("[TB] FAIL hop_out_count: got %0d expected 32", txData.size() - txBase); end
    if (txData.size() - txBase >= 32) begin
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (txData[txBase+k] !== expData(16'(base + k)) || txLast[txBase+k] !== (k == 31) || txUser[txBase+k] !== 8'd0) begin
          failures++;
          $display("[TB] FAIL hop_sample_%0d: got data=%h last=%b user=%0d expected data=%h last=%b user=0",
                   k, txData[txBase+k], txLast[txBase+k], txUser[txBase+k], expData(16'(base + k)), (k == 31));
        end
      end
    end
    checks++; if (errCount - errBase !== 0) begin failures++; $display("[TB] FAIL hop_no_sync_err: got %0d expected 0", errCount - errBase); end
  endtask

  task automatic test_short_sync();
    int txBase;
    int errBase;
    doReset();
    txBase = txData.size();
    errBase = errCount;
    sendSync(10);
    sendData(1);
    checks++; if (sync_err !== 1'b1) begin failures++; $display("[TB] FAIL short_sync_err: got %b expected 1", sync_err); end
    checks++; if (rx_state !== ST_IDLE) begin failures++; $display("[TB] FAIL short_state: got %b expected %b", rx_state, ST_IDLE); end
    sendData(2);
    idle(2);
    checks++; if (errCount - errBase !== 1) begin failures++; $display("[TB] FAIL short_err_cycles: got %0d expected 1", errCount - errBase); end
    checks++; if (txData.size() - txBase !== 0) begin failures++; $display("[TB] FAIL short_no_output: got %0d expected 0", txData.size() - txBase); end
    checks++; if (nhop !== 8'd0) begin failures++; $display("[TB] FAIL short_nhop: got %0d expected 0", nhop); end
  endtask

  task automatic test_window_edges();
    doReset();
    sendSync(14);
    sendData(1);
    checks++; if (rx_state !== ST_RX) begin failures++; $display("[TB] FAIL win_14_accept: got %b expected %b", rx_state, ST_RX); end
    doReset();
    sendSync(13);
    sendData(1);
    checks++; if (rx_state !== ST_IDLE) begin failures++; $display("[TB] FAIL win_13_state: got %b expected %b", rx_state, ST_IDLE); end
    checks++; if (sync_err !== 1'b1) begin failures++; $display("[TB] FAIL win_13_err: got %b expected 1", sync_err); end
    doReset();
    sendSync(18);
    sendData(1);
    checks++; if (rx_state !== ST_RX) begin failures++; $display("[TB] FAIL win_18_accept: got %b expected %b", rx_state, ST_RX); end
  endtask

  task automatic test_long_sync();
    int txBase;
    int errBase;
    doReset();
    txBase = txData.size();
    errBase = errCount;
    sendSync(18);
    checks++; if (rx_state !== ST_MEAS) begin failures++; $display("[TB] FAIL long_meas_at18: got %b expected %b", rx_state, ST_MEAS); end
    sendSync(1);
    checks++; if (sync_err !== 1'b1) begin failures++; $display("[TB] FAIL long_err_at19: got %b expected 1", sync_err); end
    checks++; if (rx_state !== ST_WAIT) begin failures++; $display("[TB] FAIL long_wait_state: got %b expected %b", rx_state, ST_WAIT); end
`ifdef RX_HOP_SYNC_STATS_EN
    checks++; if (sync_len !== 24'd19) begin failures++; $display("[TB] FAIL long_sync_len: got %0d expected 19", sync_len); end
`endif
    sendSync(1);
    checks++; if (rx_state !== ST_WAIT) begin failures++; $display("[TB] FAIL long_wait_hold: got %b expected %b", rx_state, ST_WAIT); end
    sendData(1);
    checks++; if (rx_state !== ST_IDLE) begin failures++; $display("[TB] FAIL long_back_idle: got %b expected %b", rx_state, ST_IDLE); end
    sendData(3);
    idle(2);
    checks++; if (txData.size() - txBase !== 0) begin failures++; $display("[TB] FAIL long_no_output: got %0d expected 0", txData.size() - txBase); end
    checks++; if (errCount - errBase !== 1) begin failures++; $display("[TB] FAIL long_err_cycles: got %0d expected 1", errCount - errBase); end
  endtask

  task automatic test_hop_wrap();
    int txBase;
    logic [PW-1:0] expPh;
    logic [HW-1:0] expHop;
    doReset();
    txBase = txData.size();
    for (int h = 0; h < 4; h++) begin
      sendSync(16);
      sendData(32);
      expHop = HW'((h + 1) % 4);
      expPh = (h == 3) ? START : START + PW'(h + 1) * DPH;
      checks++; if (nhop !== expHop) begin failures++; $display("[TB] FAIL wrap_nhop_%0d: got %0d expected %0d", h, nhop, expHop); end
      checks++; if (hop_ph_inc !== expPh) begin failures++; $display("[TB] FAIL wrap_ph_%0d: got %h expected %h", h, hop_ph_inc, expPh); end
    end
    idle(2);
    checks++; if (txData.size() - txBase !== 128) begin failures++; $display("[TB] FAIL wrap_count: got %0d expected 128", txData.size() - txBase); end
    if (txData.size() - txBase >= 128) begin
      for (int k = 0; k < 128; k += 31) begin
        checks++;
        if (txUser[txBase+k] !== HW'(k / 32) || txLast[txBase+k] !== ((k % 32) == 31)) begin
          failures++;
          $display("[TB] FAIL wrap_tuser_%0d: got user=%0d last=%b expected user=%0d last=%b",
                   k, txUser[txBase+k], txLast[txBase+k], k / 32, ((k % 32) == 31));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int txBase;
    logic [DW-1:0] base;
    doReset();
    txBase = txData.size();
    sendSync(16);
    base = dataCnt;
    sendData(10);
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_overflow: got %b expected 0", overflow); end
    bus.out_tready = 1'b0;
    sendData(1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL bp_overflow_set: got %b expected 1", overflow); end
    sendData(4);
    checks++; if (bus.out_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL bp_held_valid: got %b expected 1", bus.out_tvalid); end
    checks++; if (bus.out_tdata !== expData(16'(base + 9))) begin failures++; $display("[TB] FAIL bp_held_data: got %h expected %h", bus.out_tdata, expData(16'(base + 9))); end
    bus.out_tready = 1'b1;
    sendData(17);
    checks++; if (nhop !== 8'd1) begin failures++; $display("[TB] FAIL bp_nhop: got %0d expected 1", nhop); end
    idle(2);
    checks++; if (txData.size() - txBase !== 27) begin failures++; $display("[TB] FAIL bp_count: got %0d expected 27", txData.size() - txBase); end
    if (txData.size() - txBase >= 27) begin
      checks++; if (txData[txBase+10] !== expData(16'(base + 15))) begin failures++; $display("[TB] FAIL bp_after_drop: got %h expected %h", txData[txBase+10], expData(16'(base + 15))); end
      checks++;
      if (txData[txBase+26] !== expData(16'(base + 31)) || txLast[txBase+26] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_last: got data=%h last=%b expected data=%h last=1", txData[txBase+26], txLast[txBase+26], expData(16'(base + 31)));
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL bp_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_early_sync();
    int txBase;
    int errBase;
    doReset();
    txBase = txData.size();
    errBase = errCount;
    sendSync(16);
    sendData(20);
    sendSync(1);
    checks++; if (sync_err !== 1'b1) begin failures++; $display("[TB] FAIL early_err: got %b expected 1", sync_err); end
    checks++; if (rx_state !== ST_MEAS) begin failures++; $display("[TB] FAIL early_state: got %b expected %b", rx_state, ST_MEAS); end
    checks++; if (nhop !== 8'd1) begin failures++; $display("[TB] FAIL early_nhop: got %0d expected 1", nhop); end
    checks++; if (hop_ph_inc !== START + DPH) begin failures++; $display("[TB] FAIL early_ph: got %h expected %h", hop_ph_inc, START + DPH); end
    sendSync(14);
    sendData(1);
    checks++; if (rx_state !== ST_RX) begin failures++; $display("[TB] FAIL early_resync: got %b expected %b", rx_state, ST_RX); end
    idle(2);
    checks++; if (txData.size() - txBase !== 21) begin failures++; $display("[TB] FAIL early_count: got %0d expected 21", txData.size() - txBase); end
    if (txData.size() - txBase >= 21) begin
      checks++; if (txLast[txBase+19] !== 1'b0) begin failures++; $display("[TB] FAIL early_no_tlast: got %b expected 0", txLast[txBase+19]); end
      checks++; if (txUser[txBase+20] !== 8'd1) begin failures++; $display("[TB] FAIL early_new_tuser: got %0d expected 1", txUser[txBase+20]); end
    end
    checks++; if (errCount - errBase !== 1) begin failures++; $display("[TB] FAIL early_err_cycles: got %0d expected 1", errCount - errBase); end
  endtask

  task automatic test_reset_midhop();
    doReset();
    sendSync(16);
    sendData(3);
    bus.out_tready = 1'b0;
    sendData(2);
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_overflow: got %b expected 1", overflow); end
    reset = 1'b1;
    drive(1'b1, 1'b1);
    checks++; if (rx_state !== ST_IDLE) begin failures++; $display("[TB] FAIL mid_state: got %b expected %b", rx_state, ST_IDLE); end
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL mid_tvalid: got %b expected 0", bus.out_tvalid); end
    checks++; if (bus.out_tdata !== 32'h0) begin failures++; $display("[TB] FAIL mid_tdata: got %h expected 0", bus.out_tdata); end
    checks++; if (symbN !== 16'h0) begin failures++; $display("[TB] FAIL mid_symbN: got %0d expected 0", symbN); end
    checks++; if (hop_ph_inc !== START) begin failures++; $display("[TB] FAIL mid_ph: got %h expected %h", hop_ph_inc, START); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL mid_overflow: got %b expected 0", overflow); end
    reset = 1'b0;
    bus.out_tready = 1'b1;
    idle(1);
  endtask

  initial begin
    reset = 1'b1;
    sync_in = 1'b0;
    bus.in_tvalid = 1'b0;
    bus.irx = '0;
    bus.qrx = '0;
    bus.out_tready = 1'b1;
    test_reset();
    test_single_hop();
    test_short_sync();
    test_window_edges();
    test_long_sync();
    test_hop_wrap();
    test_backpressure();
    test_early_sync();
    test_reset_midhop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
